// File: rtl/dmem_dma.sv
// Word-granular DMA engine for a single-port data memory: copies a block
// (read/write alternating) or fills a block with a constant, and sums the words written.
module dmem_dma #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] sum,
    output logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_rd,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] i_inc;
    logic [DATA_W-1:0] wr_data;

    assign i_inc   = i_q + ADDR_W'(1);
    assign wr_data = mode_q ? fill_q : data_q;
    assign sum     = sum_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        i_d     = i_q;
        fill_d  = fill_q;
        data_d  = data_q;
        sum_d   = sum_q;
        busy    = 1'b0;
        done    = 1'b0;
        mem_we  = 1'b0;
        mem_a   = '0;
        mem_wd  = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src;
                    dst_d  = dst;
                    len_d  = len;
                    fill_d = fill_val;
                    sum_d  = '0;
                    i_d    = '0;
                    if (len == '0)  state_d = DONE;
                    else if (mode)  state_d = WRITE;
                    else            state_d = READ;
                end
            end
            READ: begin
                busy    = 1'b1;
                mem_a   = src_q + i_q;
                data_d  = mem_rd;
                state_d = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                mem_a  = dst_q + i_q;
                mem_wd = wr_data;
                sum_d  = sum_q + wr_data;
                i_d    = i_inc;
                // Copy interleaves a read before every write; fill streams writes back to back.
                if (i_inc == len_q) state_d = DONE;
                else if (mode_q)    state_d = WRITE;
                else                state_d = READ;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            i_q     <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            i_q     <= i_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_dmem_dma.sv
// Randomized bench for dmem_dma: a per-transfer reference model predicts every
// cycle's memory-port activity, the completion pulse, the running sum and memory contents.
module tb_dmem_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [15:0] len = '0;
    logic [31:0] fill_val = '0;
    logic        busy, done, mem_we;
    logic [31:0] sum, mem_wd, mem_rd;
    logic [15:0] mem_a;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        load_req = 1'b1;
    int          wr_count = 0;
    int          n_chk = 0;
    int          n_err = 0;

    dmem_dma #(.DATA_W(32), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done), .sum(sum),
        .mem_a(mem_a), .mem_rd(mem_rd), .mem_wd(mem_wd), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a];

    function automatic logic [31:0] base_word(input int a);
        case (a)
            0: return 32'h070a0001;
            1: return 32'h00020102;
            2: return 32'h01030203;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < 65536; a++) mem[a] <= base_word(a);
        end else if (mem_we) begin
            mem[mem_a] <= mem_wd;
            wr_count   <= wr_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] port_vec();
        return {13'b0, busy, done, mem_we, mem_a, mem_wd};
    endfunction

    function automatic logic [63:0] exp_vec(input bit b, input bit dn, input bit we,
                                            input logic [15:0] a, input logic [31:0] wd);
        return {13'b0, b, dn, we, a, wd};
    endfunction

    task automatic noise(input bit hold);
        if (hold) begin
            start    = 1'b1;
            mode     = 1'($urandom);
            src      = 16'($urandom);
            dst      = 16'($urandom);
            len      = 16'($urandom);
            fill_val = $urandom;
        end else begin
            start = 1'b0;
        end
    endtask

    // Issue one transfer and check every cycle from accept to the idle cycle after done.
    task automatic xfer(input bit m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] n, input logic [31:0] fv, input bit hold);
        logic [31:0] esum;
        logic [31:0] w;
        logic [15:0] ra, wa;
        @(negedge clk);
        start = 1'b1; mode = m; src = s; dst = d; len = n; fill_val = fv;
        @(posedge clk);
        esum = '0;
        for (int j = 0; j < int'(n); j++) begin
            ra = s + 16'(j);
            wa = d + 16'(j);
            if (!m) begin
                @(negedge clk); noise(hold);
                chk("read_cycle", port_vec(), exp_vec(1, 0, 0, ra, 32'h0));
            end
            w = m ? fv : ref_mem[ra];
            @(negedge clk); noise(hold);
            chk("write_cycle", port_vec(), exp_vec(1, 0, 1, wa, w));
            ref_mem[wa] = w;
            esum += w;
        end
        @(negedge clk); start = 1'b0;
        chk("done_cycle", port_vec(), exp_vec(0, 1, 0, 16'h0, 32'h0));
        chk("done_sum", {32'h0, sum}, {32'h0, esum});
        @(negedge clk);
        chk("idle_after", port_vec(), exp_vec(0, 0, 0, 16'h0, 32'h0));
        chk("sum_hold", {32'h0, sum}, {32'h0, esum});
        for (int j = 0; j < int'(n); j++) begin
            wa = d + 16'(j);
            chk("mem_contents", {32'h0, mem[wa]}, {32'h0, ref_mem[wa]});
        end
    endtask

    initial begin
        int wc;
        for (int a = 0; a < 65536; a++) ref_mem[a] = base_word(a);
        #1;
        chk("reset_ports", port_vec(), exp_vec(0, 0, 0, 16'h0, 32'h0));
        chk("reset_sum", {32'h0, sum}, 64'h0);
        @(negedge clk); @(negedge clk);
        load_req = 1'b0;
        rst_n = 1'b1;

        // Copy of the three seeded words, 7 cycles accept-to-done.
        xfer(0, 16'h0000, 16'h0010, 16'd3, 32'h0, 0);
        chk("copy_sum_const", {32'h0, sum}, 64'h080F0306);
        // Fill of four words.
        xfer(1, 16'h0000, 16'h0020, 16'd4, 32'hDEADBEEF, 0);
        chk("fill_sum_const", {32'h0, sum}, 64'h7AB6FBBC);
        // Zero length in both modes.
        xfer(0, 16'h0005, 16'h0030, 16'd0, 32'h0, 0);
        chk("len0_copy_sum", {32'h0, sum}, 64'h0);
        xfer(1, 16'h0005, 16'h0030, 16'd0, 32'h1234_5678, 0);
        chk("len0_fill_sum", {32'h0, sum}, 64'h0);
        // Destination address wraps.
        xfer(1, 16'h0000, 16'hFFFF, 16'd2, 32'h5, 0);
        chk("wrap_sum_const", {32'h0, sum}, 64'hA);
        chk("wrap_mem0", {32'h0, mem[0]}, 64'h5);
        // start held high with changing operands throughout a transfer.
        xfer(0, 16'h0040, 16'h0050, 16'd2, 32'h0, 1);
        // Overlapping copy replicates the first source word (mem[0] is 5 after the wrap fill).
        xfer(0, 16'h0000, 16'h0001, 16'd3, 32'h0, 0);
        for (int j = 1; j <= 3; j++) chk("overlap_rep", {32'h0, mem[j]}, 64'h5);

        // Reset during the second write of a 5-word copy.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 16'h0060; dst = 16'h0080; len = 16'd5;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("rst_read1", port_vec(), exp_vec(1, 0, 0, 16'h0060, 32'h0));
        @(negedge clk);
        chk("rst_write1", port_vec(), exp_vec(1, 0, 1, 16'h0080, ref_mem[16'h0060]));
        ref_mem[16'h0080] = ref_mem[16'h0060];
        @(negedge clk);
        chk("rst_read2", port_vec(), exp_vec(1, 0, 0, 16'h0061, 32'h0));
        @(negedge clk);
        chk("rst_write2", port_vec(), exp_vec(1, 0, 1, 16'h0081, ref_mem[16'h0061]));
        wc = wr_count;
        rst_n = 1'b0;
        #1;
        chk("rst_abort_ports", port_vec(), exp_vec(0, 0, 0, 16'h0, 32'h0));
        chk("rst_abort_sum", {32'h0, sum}, 64'h0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_held", port_vec(), exp_vec(0, 0, 0, 16'h0, 32'h0));
        end
        chk("rst_no_write", 64'(wr_count), 64'(wc));
        chk("rst_mem_untouched", {32'h0, mem[16'h0081]}, {32'h0, ref_mem[16'h0081]});
        rst_n = 1'b1;
        xfer(1, 16'h0000, 16'h0090, 16'd1, 32'hCAFE_F00D, 0);
        chk("post_rst_sum", {32'h0, sum}, 64'hCAFE_F00D);

        // Randomized transfers, some straddling the top of the address space.
        for (int t = 0; t < 30; t++) begin
            logic [15:0] rs, rd;
            rs = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                             : 16'($urandom_range(0, 255));
            rd = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                             : 16'($urandom_range(0, 255));
            xfer(1'($urandom), rs, rd, 16'($urandom_range(0, 9)), $urandom,
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
